// File: rtl/id_issue_stage.sv
// Decode/issue stage: regfile read addressing, load-use busy scoreboard, ID/EX pipeline register.
// Build option: define ISSUE_BYPASS_EN to forward same-cycle write-back data instead of stalling on it.
module id_issue_stage #(
   parameter int         width     = 32,
   parameter int         addrWidth = 5,
   parameter logic [6:0] LOAD_OP   = 7'b0000011
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 if_valid,
   input  logic [width-1:0]     if_instr,
   input  logic [width-1:0]     if_pc,
   output logic                 if_ready,
   output logic [addrWidth-1:0] rf_addrA,
   output logic [addrWidth-1:0] rf_addrB,
   input  logic [width-1:0]     rf_dataA,
   input  logic [width-1:0]     rf_dataB,
   input  logic                 wb_we,
   input  logic [addrWidth-1:0] wb_addr,
   input  logic [width-1:0]     wb_data,
   input  logic                 flush,
   output logic                 ex_valid,
   input  logic                 ex_ready,
   output logic [width-1:0]     ex_instr,
   output logic [width-1:0]     ex_pc,
   output logic [width-1:0]     ex_opA,
   output logic [width-1:0]     ex_opB,
   output logic [addrWidth-1:0] ex_rd
);

   localparam int NREG = 1 << addrWidth;

   logic [addrWidth-1:0] rs1;
   logic [addrWidth-1:0] rs2;
   logic [addrWidth-1:0] rd;
   logic                 is_load;
   logic [NREG-1:0]      busy;
   logic [NREG-1:0]      busy_eff;
   logic [NREG-1:0]      busy_next;
   logic                 held_load;
   logic                 wb_hazard;
   logic                 hazard;
   logic                 slot_free;
   logic                 issue;
   logic                 kill_load;
   logic [width-1:0]     op_a;
   logic [width-1:0]     op_b;

   assign rs1      = if_instr[15 +: addrWidth];
   assign rs2      = if_instr[20 +: addrWidth];
   assign rd       = if_instr[7 +: addrWidth];
   assign is_load  = (if_instr[6:0] == LOAD_OP);
   assign rf_addrA = rs1;
   assign rf_addrB = rs2;

   // A write-back landing this cycle releases its busy bit for the hazard check right away.
   always_comb begin
      busy_eff = busy;
      if (wb_we) busy_eff[wb_addr] = 1'b0;
      busy_eff[0] = 1'b0;
   end

`ifdef ISSUE_BYPASS_EN
   assign wb_hazard = 1'b0;
`else
   assign wb_hazard = wb_we & (wb_addr != '0) & ((wb_addr == rs1) | (wb_addr == rs2));
`endif

   assign hazard = busy_eff[rs1] | busy_eff[rs2] | (is_load & busy_eff[rd]) | wb_hazard;

   // Handshakes: IF->ID transfers when if_valid & if_ready at a rising edge; ID/EX->EX transfers
   // when ex_valid & ex_ready. if_ready never looks at if_valid, and ex_* hold while unconsumed.
   assign slot_free = ~ex_valid | ex_ready;
   assign if_ready  = ~hazard & slot_free & ~flush;
   assign issue     = if_valid & if_ready & ~clear;

   // Only a load still sitting unconsumed in ID/EX gets its busy bit retracted by a flush.
   assign kill_load = flush & held_load & ~ex_ready;

   always_comb begin
      busy_next = busy;
      if (wb_we) busy_next[wb_addr] = 1'b0;
      if (kill_load) busy_next[ex_rd] = 1'b0;
      if (issue & is_load) busy_next[rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   function automatic logic [width-1:0] pick_operand(
      input logic [addrWidth-1:0] rs,
      input logic [width-1:0]     rf_data,
      input logic                 we,
      input logic [addrWidth-1:0] wa,
      input logic [width-1:0]     wd
   );
      logic [width-1:0] value;
      value = rf_data;
`ifdef ISSUE_BYPASS_EN
      if (we && (wa == rs)) value = wd;
`else
      if (we && (wa == rs)) value = rf_data;
`endif
      if (rs == '0) value = '0;
      return value;
   endfunction

   assign op_a = pick_operand(rs1, rf_dataA, wb_we, wb_addr, wb_data);
   assign op_b = pick_operand(rs2, rf_dataB, wb_we, wb_addr, wb_data);

   always_ff @(posedge clock) begin
      if (clear) begin
         ex_valid  <= 1'b0;
         ex_instr  <= '0;
         ex_pc     <= '0;
         ex_opA    <= '0;
         ex_opB    <= '0;
         ex_rd     <= '0;
         busy      <= '0;
         held_load <= 1'b0;
      end else begin
         busy <= busy_next;
         if (issue) begin
            ex_valid  <= 1'b1;
            ex_instr  <= if_instr;
            ex_pc     <= if_pc;
            ex_opA    <= op_a;
            ex_opB    <= op_b;
            ex_rd     <= rd;
            held_load <= is_load & (rd != '0);
         end else if (slot_free | flush) begin
            ex_valid  <= 1'b0;
            held_load <= 1'b0;
         end
      end
   end

endmodule
